integration_control_data_mem: RTL and testbench
===============================================

Name: integration_control_data_mem

Overview:
- Integration of the stack processor's instruction control decode with the word-addressed data memory.
- Decodes one 16-bit instruction per cycle and produces:
  - the value to be pushed onto the operand stack (stackWriteData);
  - the jump target (newPC).
- Performs data-memory stores for pop.
- Sits between instruction fetch / PC logic and the operand-stack block of the processor datapath.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 12, data-memory address width; address taken from inst[ADDR_W-1:0].
- DEPTH, 4096, data-memory words (2**ADDR_W).

Ports:
- CLK  input  1  system clock; memory writes occur on rising edge.
- reset  input  1  asynchronous, active-low reset.
- inst  input  16  current instruction; opcode inst[15:12], immediate/address inst[11:0], funct inst[3:0].
- memWriteData  input  16  value written to data memory by pop (top of stack supplied by stack block).
- getinData  input  16  external input port value for getin.
- newPC  output  16  jump target address.
- stackWriteData  output  16  value to push onto the operand stack.

Behaviour:
- Interface (already decided): one clock, CLK; reset is asynchronous and active-low, port name reset.

Decode of stackWriteData and newPC:
- Both outputs are purely combinational from inst, getinData and memory read data. No output registers, so no reset value.
- Opcode 0x0, funct 0x4 (getin): stackWriteData = getinData.
- Opcode 0x3 (j): newPC = {3'b0, inst[11:0], 1'b0}, i.e. immediate << 1 (byte address). Example: 0x3005 -> 0x000A.
- Opcode 0x5 (pop addr): on the rising CLK edge, mem[inst[11:0]] <= memWriteData. stackWriteData = 0.
- Opcode 0x6 (push addr): stackWriteData = mem[inst[11:0]].
  - Asynchronous (combinational) read.
  - Reflects a pop written on the preceding edge.
- Opcode 0x7 (pushi imm): stackWriteData = {4'b0, inst[11:0]} (zero-extended).
- Opcode 0x8 (lui imm): stackWriteData = {inst[3:0], 12'b0}. Example: 0x8003 -> 0x3000.
- All other opcodes/functs: stackWriteData = 0; no memory write.
- newPC = 0 for every non-j instruction.

Data memory:
- DEPTH x DATA_W, single write port, single asynchronous read port.
- Power-up content: mem[i] = i (low 16 bits of i).
- reset does not clear contents.
- While reset is low, writes are suppressed.
- Read/write same address in one cycle: the read returns old data until the edge, then new data.
- Address wraps naturally within ADDR_W bits; no out-of-range case.

Latency:
- Decode outputs: 0 cycles.
- Pop: visible to a push 1 cycle later.

Decomposition:
- Shared package (e.g. stack_proc_pkg) holds:
  - opcode constants OP_FUNCT=0x0, OP_J=0x3, OP_POP=0x5, OP_PUSH=0x6, OP_PUSHI=0x7, OP_LUI=0x8;
  - FN_GETIN=0x4;
  - DATA_W/ADDR_W defaults.
- One natural sub-module: data_memory (async-read, sync-write RAM with mem[i]=i init and write-enable gated by reset).
- Decode/muxing stays in the top.

Test Plan (reset held high, i.e. deasserted, after an initial low pulse):
- reset low pulse mid-sim while inst=0x5002, memWriteData=0x1234 -> mem[2] unchanged; push 0x6002 then returns 0x0002.
- getinData=0x13, inst=0x0004 -> stackWriteData=0x0013; inst=0x0005 -> stackWriteData=0.
- inst=0x3005 -> newPC=0x000A; inst=0x3FFF -> newPC=0x1FFE; inst=0x7003 -> newPC=0.
- inst=0x8003 -> stackWriteData=0x3000; inst=0x7003 -> 0x0003; inst=0x7FFF -> 0x0FFF.
- inst=0x6005 with no prior writes -> stackWriteData=0x0005.
- inst=0x5002, memWriteData=0x3333 for one edge, then inst=0x6002 -> stackWriteData=0x3333; 0x6003 still 0x0003.

Source files
------------

// File: rtl/integration_control_data_mem_pkg.sv
// Shared definitions for the stack processor control/data-memory slice.
// Holds the major opcodes, the funct code for getin and the default data
// and address widths used by the decode top and the data memory.
package integration_control_data_mem_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned INST_W     = 16;

  // Major opcode, inst[15:12]
  typedef enum logic [3:0] {
    OP_FUNCT = 4'h0,
    OP_J     = 4'h3,
    OP_POP   = 4'h5,
    OP_PUSH  = 4'h6,
    OP_PUSHI = 4'h7,
    OP_LUI   = 4'h8
  } opcode_t;

  // Function code, inst[3:0], for OP_FUNCT instructions
  typedef enum logic [3:0] {
    FN_GETIN = 4'h4
  } funct_t;

endpackage

// File: rtl/integration_control_data_mem_data_memory.sv
// Word-addressed data memory: single synchronous write port, single
// asynchronous read port. Each word powers up holding its own address.
// Contents survive reset; the caller gates writeEn with reset.
// Ports:
//   clk       - write clock (rising edge)
//   writeEn   - write strobe, sampled on the rising edge
//   addr      - shared read/write word address
//   writeData - word to store
//   readData  - combinational read of mem[addr] (old data until the edge)
module integration_control_data_mem_data_memory #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData
);

  typedef logic [DATA_W-1:0] memArray_t [DEPTH];

  function automatic memArray_t identityContents();
    memArray_t c;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      c[i] = DATA_W'(i);
    end
    return c;
  endfunction

  // Power-up image mem[i] = i, carried as a declaration initialiser so no
  // reset path ever touches the array.
  memArray_t mem = identityContents();

  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[addr] <= writeData;
    end
  end

  assign readData = mem[addr];

endmodule

// File: rtl/integration_control_data_mem.sv
// Instruction control decode merged with the data memory.
// Decodes one instruction per cycle into the operand-stack push value and
// the jump target; pop stores the top of stack into data memory.
// Ports:
//   CLK            - system clock; memory writes on rising edge
//   reset          - asynchronous active-low reset; blocks memory writes
//   inst           - instruction: opcode [15:12], imm/addr [11:0], funct [3:0]
//   memWriteData   - top-of-stack value stored by pop
//   getinData      - external input port value for getin
//   newPC          - jump target (byte address), 0 for non-jumps
//   stackWriteData - value to push onto the operand stack
module integration_control_data_mem
  import integration_control_data_mem_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [INST_W-1:0] inst,
  input  logic [DATA_W-1:0] memWriteData,
  input  logic [DATA_W-1:0] getinData,
  output logic [DATA_W-1:0] newPC,
  output logic [DATA_W-1:0] stackWriteData
);

  opcode_t           opcode;
  logic [3:0]        funct;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memReadData;
  logic              memWriteEn;

  assign opcode  = opcode_t'(inst[15:12]);
  assign funct   = inst[3:0];
  assign memAddr = inst[ADDR_W-1:0];

  always_comb begin
    stackWriteData = '0;
    newPC          = '0;
    memWriteEn     = 1'b0;
    case (opcode)
      OP_FUNCT: begin
        if (funct == FN_GETIN) begin
          stackWriteData = getinData;
        end
      end
      // Word immediate shifted left one to form a byte address
      OP_J:     newPC = {{(DATA_W-ADDR_W-1){1'b0}}, inst[ADDR_W-1:0], 1'b0};
      // Store is suppressed for as long as reset is held low
      OP_POP:   memWriteEn = reset;
      OP_PUSH:  stackWriteData = memReadData;
      OP_PUSHI: stackWriteData = {{(DATA_W-ADDR_W){1'b0}}, inst[ADDR_W-1:0]};
      OP_LUI:   stackWriteData = {inst[3:0], {(DATA_W-4){1'b0}}};
      default: begin
        stackWriteData = '0;
      end
    endcase
  end

  integration_control_data_mem_data_memory #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) uDataMemory (
    .clk      (CLK),
    .writeEn  (memWriteEn),
    .addr     (memAddr),
    .writeData(memWriteData),
    .readData (memReadData)
  );

endmodule

// File: tb/tb_integration_control_data_mem.sv
// Scoreboard bench: the driver applies a vector just after a rising edge and
// queues the hand-computed expected outputs; the monitor drains the queue on
// each falling edge and compares against the DUT.
module tb_integration_control_data_mem;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] inst = 16'h0000;
  logic [15:0] memWriteData = 16'h0000;
  logic [15:0] getinData = 16'h0000;
  logic [15:0] newPC;
  logic [15:0] stackWriteData;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic [15:0] expPC;
    logic [15:0] expSwd;
  } expect_t;

  expect_t sb[$];

  always #5 CLK = ~CLK;

  integration_control_data_mem dut (
    .CLK           (CLK),
    .reset         (reset),
    .inst          (inst),
    .memWriteData  (memWriteData),
    .getinData     (getinData),
    .newPC         (newPC),
    .stackWriteData(stackWriteData)
  );

  // Monitor: outputs are combinational, so every queued entry is due at the
  // falling edge following its stimulus.
  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      expect_t e;
      e = sb.pop_front();
      compared++;
      if (newPC !== e.expPC) begin
        mismatched++;
        $display("FAIL %s newPC: got 0x%04h expected 0x%04h", e.name, newPC, e.expPC);
      end
      compared++;
      if (stackWriteData !== e.expSwd) begin
        mismatched++;
        $display("FAIL %s stackWriteData: got 0x%04h expected 0x%04h",
                 e.name, stackWriteData, e.expSwd);
      end
    end
  end

  task automatic apply(input string name, input logic [15:0] i, input logic [15:0] wd,
                       input logic [15:0] expPC, input logic [15:0] expSwd);
    expect_t e;
    @(posedge CLK);
    #1;
    inst = i;
    memWriteData = wd;
    e.name = name;
    e.expPC = expPC;
    e.expSwd = expSwd;
    sb.push_back(e);
  endtask

  initial begin
    int budget;
    // Initial reset pulse
    repeat (2) @(posedge CLK);
    #1 reset = 1'b1;

    // getin and a non-getin funct
    getinData = 16'h0013;
    apply("getin",      16'h0004, 16'h0000, 16'h0000, 16'h0013);
    apply("funct5",     16'h0005, 16'h0000, 16'h0000, 16'h0000);
    // jumps
    apply("j5",         16'h3005, 16'h0000, 16'h000A, 16'h0000);
    apply("jmax",       16'h3FFF, 16'h0000, 16'h1FFE, 16'h0000);
    // immediates
    apply("pushi3",     16'h7003, 16'h0000, 16'h0000, 16'h0003);
    apply("lui3",       16'h8003, 16'h0000, 16'h0000, 16'h3000);
    apply("pushimax",   16'h7FFF, 16'h0000, 16'h0000, 16'h0FFF);
    apply("opUnused",   16'h1234, 16'h0000, 16'h0000, 16'h0000);
    // power-up memory image
    apply("pushInit5",  16'h6005, 16'h0000, 16'h0000, 16'h0005);
    // pop then push, neighbour untouched
    apply("pop2",       16'h5002, 16'h3333, 16'h0000, 16'h0000);
    apply("push2",      16'h6002, 16'h0000, 16'h0000, 16'h3333);
    apply("push3",      16'h6003, 16'h0000, 16'h0000, 16'h0003);
    // top address
    apply("pushInitTop",16'h6FFF, 16'h0000, 16'h0000, 16'h0FFF);
    apply("popTop",     16'h5FFF, 16'hBEEF, 16'h0000, 16'h0000);
    apply("pushTop",    16'h6FFF, 16'h0000, 16'h0000, 16'hBEEF);

    // Reset mid-run with a pop on the bus: no write may land
    @(posedge CLK);
    #1;
    reset = 1'b0;
    inst = 16'h5004;
    memWriteData = 16'h1234;
    apply("popInReset", 16'h5004, 16'h1234, 16'h0000, 16'h0000);
    @(posedge CLK);
    #1;
    reset = 1'b1;
    inst = 16'h6004;
    sb.push_back('{"pushAfterReset", 16'h0000, 16'h0004});
    // Memory contents survive reset
    apply("pushKept",   16'h6002, 16'h0000, 16'h0000, 16'h3333);

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge CLK);
      budget--;
    end
    @(posedge CLK);
    if (sb.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
